// File: rtl/exp_batch_driver.sv
// Batches operands through an external exponential core: operand FIFO -> one-at-a-time
// core handshake with a per-operand timeout -> result FIFO, results kept in operand order.
module exp_batch_driver #(
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [17:0] out_data,
  input  logic        out_ready,
  output logic        exp_start,
  output logic [15:0] exp_x,
  input  logic        exp_done,
  input  logic [17:0] exp_result,
  output logic        busy,
  output logic        timeout_err,
  input  logic        clear_err
);

  localparam int unsigned XW  = 16;
  localparam int unsigned RW  = 18;
  localparam int unsigned IAW = $clog2(IN_DEPTH);
  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam int unsigned ICW = IAW + 1;
  localparam int unsigned OCW = OAW + 1;
  localparam int unsigned CW  = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_ACK  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]     state;
  logic [1:0]     state_next;
  logic           timeout_hit;
  logic [CW-1:0]  cnt;

  logic [XW-1:0]  in_mem [IN_DEPTH];
  logic [IAW-1:0] in_wr;
  logic [IAW-1:0] in_rd;
  logic [ICW-1:0] in_cnt;

  logic [RW-1:0]  out_mem [OUT_DEPTH];
  logic [OAW-1:0] out_wr;
  logic [OAW-1:0] out_rd;
  logic [OCW-1:0] out_cnt;

  logic in_push;
  logic in_pop;
  logic out_push;
  logic out_pop;
  logic start_ok;

  // The pop in ISSUE frees a slot on the same edge, so a full FIFO still accepts then.
  assign in_pop    = (state == ISSUE);
  assign in_ready  = (in_cnt != ICW'(IN_DEPTH)) || in_pop;
  assign in_push   = in_valid && in_ready;
  assign out_push  = (state == WAIT_DONE) && exp_done;
  assign out_valid = (out_cnt != '0);
  assign out_pop   = out_valid && out_ready;
  assign out_data  = out_valid ? out_mem[out_rd] : '0;
  assign exp_start = in_pop;
  assign busy      = (state != IDLE);
  assign start_ok  = (in_cnt != '0) && (out_cnt < OCW'(OUT_DEPTH)) && exp_done;

  // Next-state decode
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:      if (start_ok) state_next = ISSUE;
      ISSUE:     state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (!exp_done) begin
          state_next = WAIT_DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (exp_done) begin
          state_next = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Cycles spent waiting on the core for the current operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          cnt <= '0;
    else if (state == WAIT_ACK || state == WAIT_DONE) cnt <= cnt + CW'(1);
    else                                              cnt <= '0;
  end

  // Operand latched as ISSUE is entered and held for the whole transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        exp_x <= '0;
    else if (state == IDLE && start_ok) exp_x <= in_mem[in_rd];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
    else if (clear_err)   timeout_err <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wr  <= '0;
      in_rd  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) in_wr <= in_wr + IAW'(1);
      if (in_pop)  in_rd <= in_rd + IAW'(1);
      case ({in_push, in_pop})
        2'b10:   in_cnt <= in_cnt + ICW'(1);
        2'b01:   in_cnt <= in_cnt - ICW'(1);
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr] <= exp_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wr  <= '0;
      out_rd  <= '0;
      out_cnt <= '0;
    end else begin
      if (out_push) out_wr <= out_wr + OAW'(1);
      if (out_pop)  out_rd <= out_rd + OAW'(1);
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + OCW'(1);
        2'b01:   out_cnt <= out_cnt - OCW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_batch_driver.sv
// Directed bench for exp_batch_driver; a core model returns {2'b01, x} twelve cycles after
// dropping done, or ignores the start (timeout) or lets the bench drive done by hand.
module tb_exp_batch_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [17:0] out_data;
  logic        out_ready;
  logic        exp_start;
  logic [15:0] exp_x;
  logic        exp_done;
  logic [17:0] exp_result;
  logic        busy;
  logic        timeout_err;
  logic        clear_err;

  int checks = 0;
  int failures = 0;
  int start_count = 0;
  int mode = 0;          // 0: normal core, 1: core ignores start, 2: bench drives exp_done
  int rs = 0;
  int k = 0;
  int sc0 = 0;
  logic [15:0] cur_x = '0;
  logic [15:0] issued[$];

  exp_batch_driver dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .exp_start(exp_start), .exp_x(exp_x), .exp_done(exp_done), .exp_result(exp_result),
    .busy(busy), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    chk("push_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [17:0] e);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(out_data), 32'(e));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),    32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid),   32'd0);
    chk({tag, "_out_data"},  32'(out_data),    32'd0);
    chk({tag, "_exp_start"}, 32'(exp_start),   32'd0);
    chk({tag, "_exp_x"},     32'(exp_x),       32'd0);
    chk({tag, "_busy"},      32'(busy),        32'd0);
    chk({tag, "_err"},       32'(timeout_err), 32'd0);
  endtask

  // Core model, acting on falling edges
  initial begin
    exp_done   = 1'b1;
    exp_result = '0;
    forever begin
      @(negedge clk);
      if (rs == 2) begin
        if (k == 0) begin
          exp_done   = 1'b1;
          exp_result = {2'b01, cur_x};
          rs = 0;
        end else begin
          k--;
        end
      end else if (rs == 1) begin
        exp_done = 1'b0;
        k  = 11;
        rs = 2;
      end
      if (exp_start) begin
        start_count++;
        issued.push_back(exp_x);
        if (mode == 0) begin
          rs    = 1;
          cur_x = exp_x;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single operand with exact latency
    push(16'h8000);
    chk("p2_no_start_yet", 32'(exp_start), 32'd0);
    @(negedge clk);
    chk("p2_start", 32'(exp_start), 32'd1);
    chk("p2_x", 32'(exp_x), 32'h8000);
    chk("p2_busy", 32'(busy), 32'd1);
    repeat (13) @(negedge clk);
    chk("p2_valid_early", 32'(out_valid), 32'd0);
    chk("p2_x_held", 32'(exp_x), 32'h8000);
    @(negedge clk);
    chk("p2_valid", 32'(out_valid), 32'd1);
    chk("p2_data", 32'(out_data), 32'h18000);
    chk("p2_idle", 32'(busy), 32'd0);
    chk("p2_starts", 32'(start_count), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("p2_popped", 32'(out_valid), 32'd0);

    // Back-pressure: result FIFO fills, no fifth issue, operand FIFO then fills
    sc0 = start_count;
    push(16'h1001); push(16'h2002); push(16'h3003); push(16'h4004);
    repeat (80) @(negedge clk);
    chk("p3_starts4", 32'(start_count - sc0), 32'd4);
    chk("p3_issue_first", 32'(issued[sc0]), 32'h1001);
    chk("p3_issue_last", 32'(issued[sc0 + 3]), 32'h4004);
    push(16'h5005);
    repeat (20) @(negedge clk);
    chk("p3_no_fifth", 32'(start_count - sc0), 32'd4);
    chk("p3_stalled_idle", 32'(busy), 32'd0);
    chk("p3_head", 32'(out_data), 32'h11001);
    push(16'h6006); push(16'h7007); push(16'h8008);
    chk("p3_in_full", 32'(in_ready), 32'd0);
    expect_result("p3_r1", 18'h11001);
    expect_result("p3_r2", 18'h12002);
    expect_result("p3_r3", 18'h13003);
    expect_result("p3_r4", 18'h14004);
    expect_result("p3_r5", 18'h15005);
    expect_result("p3_r6", 18'h16006);
    expect_result("p3_r7", 18'h17007);
    expect_result("p3_r8", 18'h18008);
    chk("p3_drained", 32'(out_valid), 32'd0);

    // Timeout with clear_err on the same edge, then a normal operand
    mode = 1;
    push(16'h0A0A);
    @(negedge clk);
    chk("p4_start", 32'(exp_start), 32'd1);
    repeat (64) @(negedge clk);
    chk("p4_err_not_yet", 32'(timeout_err), 32'd0);
    chk("p4_busy_waiting", 32'(busy), 32'd1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("p4_err_set_wins", 32'(timeout_err), 32'd1);
    chk("p4_idle", 32'(busy), 32'd0);
    chk("p4_no_result", 32'(out_valid), 32'd0);
    mode = 0;
    push(16'h0B0B);
    @(negedge clk);
    chk("p4_next_start", 32'(exp_start), 32'd1);
    chk("p4_next_x", 32'(exp_x), 32'h0B0B);
    expect_result("p4_next", 18'h10B0B);
    chk("p4_err_sticky", 32'(timeout_err), 32'd1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("p4_err_cleared", 32'(timeout_err), 32'd0);

    // Core busy holds off issue; then push into full operand FIFO on the pop edge
    mode = 2;
    exp_done = 1'b0;
    sc0 = start_count;
    push(16'h00A1); push(16'h00A2); push(16'h00A3); push(16'h00A4);
    chk("p5_in_full", 32'(in_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("p5_no_start", 32'(start_count - sc0), 32'd0);
    chk("p5_idle", 32'(busy), 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h00A5;
    mode     = 0;
    exp_done = 1'b1;
    chk("p5_full_not_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("p5_start", 32'(exp_start), 32'd1);
    chk("p5_x", 32'(exp_x), 32'h00A1);
    chk("p5_ready_on_pop", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("p5_still_full", 32'(in_ready), 32'd0);
    expect_result("p5_r1", 18'h100A1);
    expect_result("p5_r2", 18'h100A2);
    expect_result("p5_r3", 18'h100A3);
    expect_result("p5_r4", 18'h100A4);
    expect_result("p5_r5", 18'h100A5);

    // Reset during WAIT_DONE with two operands queued
    push(16'hC001); push(16'hC002); push(16'hC003);
    repeat (4) @(negedge clk);
    chk("p6_in_flight", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("p6_rst");
    rst = 1'b0;
    sc0 = start_count;
    repeat (30) @(negedge clk);
    chk("p6_no_result", 32'(out_valid), 32'd0);
    chk("p6_no_issue", 32'(start_count - sc0), 32'd0);
    chk("p6_idle", 32'(busy), 32'd0);
    chk("p6_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
